dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter: N_REQ, 2, number of requesters (fixed at 2 in this revision).
REQ-002 Parameter: AW, 6, data-memory word-address width.
REQ-003 Parameter: DW, 32, data width.
REQ-004 clk_dm  in  1  single clock; all state updates on posedge clk_dm.
REQ-005 rst_dm  in  1  synchronous, active-high reset.
REQ-006 req_i  in  2  per-requester access request, held high until that requester's ack_o bit pulses.
REQ-007 we_i  in  2  per-requester write enable (1 = write, 0 = read), stable while req_i is high.
REQ-008 addr0_i, addr1_i  in  AW each  per-requester word address, stable while req_i is high.
REQ-009 wdata0_i, wdata1_i  in  DW each  per-requester write data, stable while req_i is high.
REQ-010 ack_o  out  2  one-cycle completion pulse to the served requester.
REQ-011 rdata_o  out  DW  read data, valid only in the ack_o cycle of a read.
REQ-012 busy_o  out  1  high whenever state is not IDLE.
REQ-013 Men_Write  out  1  data-memory write strobe.
REQ-014 DM_Addr  out  AW  data-memory address.
REQ-015 M_W_Data  out  DW  data-memory write data.
REQ-016 M_R_Data  in  DW  data-memory read data, registered by the memory one clock after the address is presented.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-018 IDLE: if any req_i bit is high, SHALL pick a winner, latch its we/addr/wdata and winner index into registers, rotate the pointer, and go to ACCESS; otherwise stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: the pointer names the preferred requester; after each grant it moves to the other requester (winner+1 mod 2).
REQ-020 ACCESS: DM_Addr and M_W_Data SHALL equal the latched values, Men_Write SHALL equal the latched we, and the next state SHALL be RESP.
REQ-021 RESP: ack_o[winner] SHALL be 1 for exactly this cycle; for reads rdata_o SHALL equal M_R_Data; for writes rdata_o SHALL be 0.
REQ-022 RESP: the winner's req_i bit SHALL be masked; if the other req_i bit is high, it SHALL be granted directly (latch, go to ACCESS); otherwise go to IDLE.
REQ-023 Men_Write SHALL be 0 in every state except ACCESS; a write SHALL occur exactly once per granted write.
REQ-024 DM_Addr and M_W_Data SHALL hold their latched values outside ACCESS (no glitching to the other requester's inputs).
REQ-025 Latency SHALL be: req_i rises in cycle T (state IDLE) -> ACCESS in T+1 -> ack_o in T+2.
REQ-026 Back-to-back throughput SHALL be one access per 2 cycles when both requesters keep requesting.
REQ-027 Simultaneous requests in IDLE SHALL be resolved by the pointer only; neither requester SHALL wait more than one other access.
REQ-028 A req_i deasserted before its ack (protocol violation) SHALL NOT cancel an already latched access.
REQ-029 rdata_o SHALL be 0 whenever ack_o is 0.

Reset
REQ-030 When rst_dm is high at a posedge, state SHALL become IDLE, pointer 0, latched we/addr/wdata/winner 0.
REQ-031 In the cycle after reset: ack_o=0, rdata_o=0, busy_o=0, Men_Write=0, DM_Addr=0, M_W_Data=0.
REQ-032 Reset during ACCESS or RESP SHALL abort: no ack_o pulse is issued for the aborted access.

Structure
REQ-033 Package dm_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESP), AW and DW constants.
REQ-034 One sub-module dm_rr_pick (combinational 2-way round-robin pick: req, pointer -> grant valid, winner index) SHALL be used.

Verification
REQ-035 Single write: req0 with addr 0x05, data 0xDEADBEEF -> Men_Write high for exactly 1 cycle (T+1), ack_o=01 at T+2.
REQ-036 Read-back: req1 read addr 0x05 after REQ-035 -> ack_o=10 at T+2 with rdata_o=0xDEADBEEF.
REQ-037 Contention: req_i=11 from reset (pointer 0), both reads -> acks 01 then 10, two cycles apart, correct data each.
REQ-038 Fairness: both requesters continuously request 8 accesses each -> ack order alternates 01,10,... with no gap beyond 2 cycles.
REQ-039 Reset mid-op: rst_dm asserted in ACCESS of a write to 0x3F -> no ack_o, Men_Write=0 next cycle, busy_o=0.
REQ-040 Address boundary: write 0x0F and 0x10 with different data, read both -> each returns its own data.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  // Index of the other requester in a two-way arbiter.
  function automatic logic other_idx(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester/memory bundle of the data-memory arbiter.
// The slave modport is the arbiter's view; the master modport is its environment.
interface dm_arbiter_if #(
  parameter int unsigned AW = dm_arb_pkg::AW,
  parameter int unsigned DW = dm_arb_pkg::DW
);
  import dm_arb_pkg::*;

  logic [1:0]    req_i;
  logic [1:0]    we_i;
  logic [AW-1:0] addr0_i;
  logic [AW-1:0] addr1_i;
  logic [DW-1:0] wdata0_i;
  logic [DW-1:0] wdata1_i;
  logic [1:0]    ack_o;
  logic [DW-1:0] rdata_o;
  logic          busy_o;
  logic          Men_Write;
  logic [AW-1:0] DM_Addr;
  logic [DW-1:0] M_W_Data;
  logic [DW-1:0] M_R_Data;

  modport slave (
    input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, M_R_Data,
    output ack_o, rdata_o, busy_o, Men_Write, DM_Addr, M_W_Data
  );

  modport master (
    output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, M_R_Data,
    input  ack_o, rdata_o, busy_o, Men_Write, DM_Addr, M_W_Data
  );

endinterface

// File: rtl/dm_rr_pick.sv
// Combinational two-way round-robin pick: the pointer names the preferred requester.
module dm_rr_pick (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       valid_o,
  output logic       win_o
);

  // Preferred requester wins if it asks, otherwise the other one.
  always_comb begin
    valid_o = |req_i;
    win_o   = ptr_i;
    if (!req_i[ptr_i]) begin
      win_o = ~ptr_i;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each grant takes ACCESS (strobe memory) then RESP (ack + read data).
module dm_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned AW    = dm_arb_pkg::AW,
  parameter int unsigned DW    = dm_arb_pkg::DW
) (
  input logic         clk_dm,
  input logic         rst_dm,
  dm_arbiter_if.slave bus
);
  import dm_arb_pkg::*;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic [N_REQ-1:0] req_eff;
  logic             pick_valid;
  logic             pick_win;

  // In RESP the just-served requester still holds req high; mask it so it cannot be re-granted.
  always_comb begin
    req_eff = bus.req_i;
    if (state_q == RESP) begin
      req_eff[win_q] = 1'b0;
    end
  end

  dm_rr_pick u_pick (
    .req_i   (req_eff),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .win_o   (pick_win)
  );

  // Next-state: grant from IDLE or directly from RESP, latching the winner's request.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (pick_valid) begin
          state_d = ACCESS;
          ptr_d   = other_idx(pick_win);
          win_d   = pick_win;
          we_d    = bus.we_i[pick_win];
          addr_d  = pick_win ? bus.addr1_i : bus.addr0_i;
          wdata_d = pick_win ? bus.wdata1_i : bus.wdata0_i;
        end
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: memory bus always shows latched values; strobe only in ACCESS.
  always_comb begin
    bus.ack_o     = '0;
    bus.rdata_o   = '0;
    bus.busy_o    = (state_q != IDLE);
    bus.Men_Write = (state_q == ACCESS) && we_q;
    bus.DM_Addr   = addr_q;
    bus.M_W_Data  = wdata_q;
    if (state_q == RESP) begin
      bus.ack_o[win_q] = 1'b1;
      if (!we_q) begin
        bus.rdata_o = bus.M_R_Data;
      end
    end
  end

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk_dm) begin
    if (rst_dm) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level memory/fairness model.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  logic clk_dm = 1'b0;
  logic rst_dm = 1'b1;

  dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_arbiter #(.N_REQ(2), .AW(AW), .DW(DW)) dut (
    .clk_dm (clk_dm),
    .rst_dm (rst_dm),
    .bus    (bus)
  );

  always #5 clk_dm = ~clk_dm;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory behind the arbiter: registered read, write on strobe.
  logic [DW-1:0] mem [64];
  always @(posedge clk_dm) begin
    if (bus.Men_Write) mem[bus.DM_Addr] <= bus.M_W_Data;
    bus.M_R_Data <= mem[bus.DM_Addr];
  end

  // Reference model: what each address must hold, and whether it was ever written.
  logic [DW-1:0] ref_mem [64];
  bit            ref_valid [64];
  logic          cur_we [2];
  logic [AW-1:0] cur_addr [2];
  logic [DW-1:0] cur_data [2];

  task automatic drive(input bit r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_i[r] = 1'b1;
    bus.we_i[r]  = we;
    cur_we[r] = we; cur_addr[r] = a; cur_data[r] = d;
    if (r) begin bus.addr1_i = a; bus.wdata1_i = d; end
    else begin bus.addr0_i = a; bus.wdata0_i = d; end
  endtask

  task automatic commit(input bit r);
    if (cur_we[r]) begin
      ref_mem[cur_addr[r]]   = cur_data[r];
      ref_valid[cur_addr[r]] = 1'b1;
    end
  endtask

  // One isolated access by requester r; observes 8 cycles after raising req.
  task automatic access(input bit r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output logic [1:0] ack, output logic [DW-1:0] rd,
                        output int mw, output int mw_cyc, output logic [AW-1:0] mw_addr,
                        output logic [DW-1:0] mw_data, output int nack);
    drive(r, we, a, d);
    lat = -1; ack = '0; rd = '0; mw = 0; mw_cyc = -1; mw_addr = '0; mw_data = '0; nack = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_dm);
      if (bus.Men_Write) begin
        mw++;
        if (mw_cyc < 0) begin mw_cyc = c; mw_addr = bus.DM_Addr; mw_data = bus.M_W_Data; end
      end
      if (bus.ack_o != 2'b00) begin
        nack++;
        if (lat < 0) begin
          lat = c; ack = bus.ack_o; rd = bus.rdata_o;
          bus.req_i[r] = 1'b0;
          commit(r);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_dm = 1'b1;
    bus.req_i = '0; bus.we_i = '0;
    bus.addr0_i = '0; bus.addr1_i = '0; bus.wdata0_i = '0; bus.wdata1_i = '0;
    @(negedge clk_dm); @(negedge clk_dm);
    rst_dm = 1'b0;
    n_checks++; if (bus.ack_o !== 2'b00) $display("FAIL rst_ack: got %b want 00", bus.ack_o); else n_pass++;
    n_checks++; if (bus.rdata_o !== '0) $display("FAIL rst_rdata: got %h want 0", bus.rdata_o); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.Men_Write !== 1'b0) $display("FAIL rst_mw: got %b want 0", bus.Men_Write); else n_pass++;
    n_checks++; if (bus.DM_Addr !== '0) $display("FAIL rst_addr: got %h want 0", bus.DM_Addr); else n_pass++;
    n_checks++; if (bus.M_W_Data !== '0) $display("FAIL rst_wdata: got %h want 0", bus.M_W_Data); else n_pass++;
  endtask

  task automatic test_single_write();
    int lat, mw, mw_cyc, nack; logic [1:0] ack; logic [DW-1:0] rd, mw_data; logic [AW-1:0] mw_addr;
    access(1'b0, 1'b1, 6'h05, 32'hDEADBEEF, lat, ack, rd, mw, mw_cyc, mw_addr, mw_data, nack);
    n_checks++; if (lat !== 2) $display("FAIL wr_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (ack !== 2'b01) $display("FAIL wr_ack: got %b want 01", ack); else n_pass++;
    n_checks++; if (rd !== '0) $display("FAIL wr_rdata: got %h want 0", rd); else n_pass++;
    n_checks++; if (mw !== 1) $display("FAIL wr_strobe_count: got %0d want 1", mw); else n_pass++;
    n_checks++; if (mw_cyc !== 1) $display("FAIL wr_strobe_cycle: got %0d want 1", mw_cyc); else n_pass++;
    n_checks++; if (mw_addr !== 6'h05) $display("FAIL wr_addr: got %h want 05", mw_addr); else n_pass++;
    n_checks++; if (mw_data !== 32'hDEADBEEF) $display("FAIL wr_data: got %h want deadbeef", mw_data); else n_pass++;
    n_checks++; if (nack !== 1) $display("FAIL wr_ack_count: got %0d want 1", nack); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL wr_idle_after: got %b want 0", bus.busy_o); else n_pass++;
  endtask

  task automatic test_read_back();
    int lat, mw, mw_cyc, nack; logic [1:0] ack; logic [DW-1:0] rd, mw_data; logic [AW-1:0] mw_addr;
    access(1'b1, 1'b0, 6'h05, '0, lat, ack, rd, mw, mw_cyc, mw_addr, mw_data, nack);
    n_checks++; if (lat !== 2) $display("FAIL rd_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (ack !== 2'b10) $display("FAIL rd_ack: got %b want 10", ack); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rd); else n_pass++;
    n_checks++; if (mw !== 0) $display("FAIL rd_no_strobe: got %0d want 0", mw); else n_pass++;
  endtask

  task automatic test_boundary();
    int lat, mw, mw_cyc, nack; logic [1:0] ack; logic [DW-1:0] rd, mw_data; logic [AW-1:0] mw_addr;
    access(1'b0, 1'b1, 6'h0F, 32'h0F0F_1111, lat, ack, rd, mw, mw_cyc, mw_addr, mw_data, nack);
    access(1'b1, 1'b1, 6'h10, 32'h1010_2222, lat, ack, rd, mw, mw_cyc, mw_addr, mw_data, nack);
    access(1'b0, 1'b0, 6'h0F, '0, lat, ack, rd, mw, mw_cyc, mw_addr, mw_data, nack);
    n_checks++; if (rd !== 32'h0F0F_1111) $display("FAIL bnd_0f: got %h want 0f0f1111", rd); else n_pass++;
    access(1'b1, 1'b0, 6'h10, '0, lat, ack, rd, mw, mw_cyc, mw_addr, mw_data, nack);
    n_checks++; if (rd !== 32'h1010_2222) $display("FAIL bnd_10: got %h want 10102222", rd); else n_pass++;
  endtask

  task automatic test_contention();
    int lat, mw, mw_cyc, nack; logic [1:0] ack; logic [DW-1:0] rd, mw_data; logic [AW-1:0] mw_addr;
    logic [1:0] seq [$]; int cyc [$]; logic [DW-1:0] dat [$];
    access(1'b0, 1'b1, 6'h0A, 32'hAAAA_0001, lat, ack, rd, mw, mw_cyc, mw_addr, mw_data, nack);
    access(1'b1, 1'b1, 6'h0B, 32'hBBBB_0002, lat, ack, rd, mw, mw_cyc, mw_addr, mw_data, nack);
    rst_dm = 1'b1;
    @(negedge clk_dm);
    rst_dm = 1'b0;
    drive(1'b0, 1'b0, 6'h0B, '0);
    drive(1'b1, 1'b0, 6'h0A, '0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_dm);
      if (bus.ack_o != 2'b00) begin
        seq.push_back(bus.ack_o); cyc.push_back(c); dat.push_back(bus.rdata_o);
        if (bus.ack_o[0]) bus.req_i[0] = 1'b0;
        if (bus.ack_o[1]) bus.req_i[1] = 1'b0;
      end
    end
    n_checks++;
    if (seq.size() != 2) $display("FAIL cont_count: got %0d want 2", seq.size());
    else begin
      n_pass++;
      n_checks++; if (seq[0] !== 2'b01) $display("FAIL cont_first: got %b want 01", seq[0]); else n_pass++;
      n_checks++; if (seq[1] !== 2'b10) $display("FAIL cont_second: got %b want 10", seq[1]); else n_pass++;
      n_checks++; if (cyc[0] != 2) $display("FAIL cont_lat: got %0d want 2", cyc[0]); else n_pass++;
      n_checks++; if (cyc[1] - cyc[0] != 2) $display("FAIL cont_gap: got %0d want 2", cyc[1] - cyc[0]); else n_pass++;
      n_checks++; if (dat[0] !== ref_mem[6'h0B]) $display("FAIL cont_data0: got %h want %h", dat[0], ref_mem[6'h0B]); else n_pass++;
      n_checks++; if (dat[1] !== ref_mem[6'h0A]) $display("FAIL cont_data1: got %h want %h", dat[1], ref_mem[6'h0A]); else n_pass++;
    end
  endtask

  task automatic test_fairness();
    int idx [2]; int mw = 0; logic [1:0] seq [$]; int cyc [$]; int cnt [2];
    idx[0] = 0; idx[1] = 0; cnt[0] = 0; cnt[1] = 0;
    drive(1'b0, 1'b1, 6'h20, $urandom);
    drive(1'b1, 1'b1, 6'h28, $urandom);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_dm);
      if (bus.Men_Write) mw++;
      if (bus.ack_o != 2'b00) begin
        seq.push_back(bus.ack_o); cyc.push_back(c);
        for (int i = 0; i < 2; i++) begin
          if (bus.ack_o[i]) begin
            commit(i[0]); idx[i]++; cnt[i]++;
            if (idx[i] < 8) drive(i[0], 1'b1, 6'h20 + 6'(i * 8 + idx[i]), $urandom);
            else bus.req_i[i] = 1'b0;
          end
        end
      end
    end
    n_checks++; if (seq.size() != 16) $display("FAIL fair_count: got %0d want 16", seq.size()); else n_pass++;
    n_checks++; if (cnt[0] != 8 || cnt[1] != 8) $display("FAIL fair_split: got %0d/%0d want 8/8", cnt[0], cnt[1]); else n_pass++;
    n_checks++; if (mw != 16) $display("FAIL fair_strobes: got %0d want 16", mw); else n_pass++;
    if (seq.size() > 0) begin
      n_checks++; if (cyc[0] != 2) $display("FAIL fair_first_lat: got %0d want 2", cyc[0]); else n_pass++;
    end
    for (int i = 1; i < seq.size(); i++) begin
      n_checks++;
      if (seq[i] === seq[i-1] || cyc[i] - cyc[i-1] != 2)
        $display("FAIL fair_alt[%0d]: got ack %b after %b gap %0d want alternate gap 2",
                 i, seq[i], seq[i-1], cyc[i] - cyc[i-1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    logic [DW-1:0] d = $urandom;
    int nack = 0;
    drive(1'b0, 1'b1, 6'h3F, d);
    @(negedge clk_dm);
    n_checks++; if (bus.Men_Write !== 1'b1) $display("FAIL mid_access_strobe: got %b want 1", bus.Men_Write); else n_pass++;
    rst_dm = 1'b1;
    @(negedge clk_dm);
    // The strobe was up at the reset edge, so the memory took the write.
    ref_mem[6'h3F] = d; ref_valid[6'h3F] = 1'b1;
    n_checks++; if (bus.ack_o !== 2'b00) $display("FAIL mid_ack: got %b want 00", bus.ack_o); else n_pass++;
    n_checks++; if (bus.Men_Write !== 1'b0) $display("FAIL mid_mw: got %b want 0", bus.Men_Write); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.DM_Addr !== '0) $display("FAIL mid_addr: got %h want 0", bus.DM_Addr); else n_pass++;
    bus.req_i = '0;
    rst_dm = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_dm);
      if (bus.ack_o != 2'b00) nack++;
    end
    n_checks++; if (nack != 0) $display("FAIL mid_no_ack: got %0d acks want 0", nack); else n_pass++;
  endtask

  task automatic test_random();
    bit pend [2]; int waits [2]; int mw = 0; int wr = 0;
    logic [1:0] ack; logic [DW-1:0] rd; logic [DW-1:0] exp;
    logic we; logic [AW-1:0] a;
    pend[0] = 0; pend[1] = 0; waits[0] = 0; waits[1] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_dm);
      ack = bus.ack_o; rd = bus.rdata_o;
      if (bus.Men_Write) mw++;
      n_checks++; if ($countones(ack) > 1) $display("FAIL rnd_onehot: got %b", ack); else n_pass++;
      if (ack == 2'b00) begin
        n_checks++; if (rd !== '0) $display("FAIL rnd_rdata_idle: got %h want 0", rd); else n_pass++;
      end
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          n_checks++; if (!pend[i]) $display("FAIL rnd_spurious_ack%0d: got ack with no request", i); else n_pass++;
          exp = cur_we[i] ? '0 : ref_mem[cur_addr[i]];
          n_checks++;
          if (rd !== exp) $display("FAIL rnd_rdata%0d: got %h want %h addr %h", i, rd, exp, cur_addr[i]);
          else n_pass++;
          if (cur_we[i]) wr++;
          commit(i[0]);
          pend[i] = 0; waits[i] = 0; bus.req_i[i] = 1'b0;
          if (pend[1-i]) begin
            waits[1-i]++;
            n_checks++;
            if (waits[1-i] > 1) $display("FAIL rnd_starve%0d: got %0d waits want <=1", 1 - i, waits[1-i]);
            else n_pass++;
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && c < 360 && $urandom_range(1, 0) == 1) begin
          we = $urandom_range(1, 0) == 1;
          a = 6'($urandom_range(63, 0));
          if (!we && !ref_valid[a]) we = 1'b1;
          drive(i[0], we, a, $urandom);
          pend[i] = 1;
        end
      end
    end
    n_checks++; if (pend[0] || pend[1]) $display("FAIL rnd_drain: got pending %b%b want 00", pend[1], pend[0]); else n_pass++;
    n_checks++; if (mw != wr) $display("FAIL rnd_write_once: got %0d strobes want %0d", mw, wr); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin ref_mem[i] = '0; ref_valid[i] = 1'b0; end
    test_reset();
    test_single_write();
    test_read_back();
    test_boundary();
    test_contention();
    test_fairness();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
